// File: rtl/stream_join_collect.sv
// Buffered stream join: collects one beat per selected lane into holding
// registers and emits a single registered multi-lane beat with a contributor mask.
package stream_join_pkg;
    typedef enum logic {
        ALL = 1'b0,
        ANY = 1'b1
    } stream_join_mode_e;
endpackage

module stream_join_collect #(
    parameter int unsigned NumInp        = 4,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 0
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumInp-1:0]                   sel_i,
    input  stream_join_pkg::stream_join_mode_e  mode_i,
    input  logic [NumInp*DataWidth-1:0]         inp_data_i,
    input  logic [NumInp-1:0]                   inp_valid_i,
    output logic [NumInp-1:0]                   inp_ready_o,
    output logic [NumInp*DataWidth-1:0]         oup_data_o,
    output logic [NumInp-1:0]                   oup_mask_o,
    output logic                                oup_timeout_o,
    output logic                                oup_valid_o,
    input  logic                                oup_ready_i,
    output logic                                busy_o
);
    import stream_join_pkg::*;

    localparam bit          TimeoutEn = (TimeoutCycles > 0);
    localparam int unsigned CntW      = TimeoutEn ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutEn ? TimeoutCycles - 1 : 0);
    localparam logic [CntW-1:0] CntMax  = CntW'(TimeoutCycles);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        OUTPUT
    } state_e;

    state_e                              state_q, state_d;
    logic [NumInp-1:0]                   sel_q, sel_d;
    stream_join_mode_e                   mode_q, mode_d;
    logic [NumInp-1:0]                   got_q, got_d;
    logic [NumInp-1:0][DataWidth-1:0]    data_q, data_d;
    logic [CntW-1:0]                     cnt_q, cnt_d;
    logic                                timeout_q, timeout_d;
    logic [NumInp*DataWidth-1:0]         oup_data_q, oup_data_d;
    logic [NumInp-1:0]                   oup_mask_q, oup_mask_d;
    logic                                oup_valid_q, oup_valid_d;
    logic                                busy_q, busy_d;

    logic [NumInp-1:0]                   accept;
    logic [NumInp-1:0]                   got_n;
    logic [NumInp-1:0][DataWidth-1:0]    inp_lanes;
    logic [NumInp-1:0][DataWidth-1:0]    masked;
    logic                                done;
    logic                                expire;

    assign inp_lanes   = inp_data_i;
    // Ready depends on registered state only, never on inp_valid_i.
    assign inp_ready_o = (state_q == COLLECT) ? (sel_q & ~got_q) : '0;

    assign oup_data_o    = oup_data_q;
    assign oup_mask_o    = oup_mask_q;
    assign oup_timeout_o = timeout_q;
    assign oup_valid_o   = oup_valid_q;
    assign busy_o        = busy_q;

    always_comb begin
        accept = inp_ready_o & inp_valid_i;
        got_n  = got_q | accept;
        done   = (mode_q == ANY) ? (|got_n) : (got_n == sel_q);
        // Completion in the expiring cycle takes precedence over the timeout.
        expire = TimeoutEn && (mode_q == ALL) && (|got_q) && (cnt_q == CntLast) && !done;

        state_d     = state_q;
        sel_d       = sel_q;
        mode_d      = mode_q;
        got_d       = got_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        timeout_d   = timeout_q;
        oup_data_d  = oup_data_q;
        oup_mask_d  = oup_mask_q;
        oup_valid_d = oup_valid_q;
        busy_d      = busy_q;

        for (int unsigned k = 0; k < NumInp; k++) begin
            if (accept[k]) begin
                data_d[k] = inp_lanes[k];
            end
        end
        for (int unsigned k = 0; k < NumInp; k++) begin
            masked[k] = got_n[k] ? data_d[k] : '0;
        end

        unique case (state_q)
            IDLE: begin
                data_d = data_q;
                if (|sel_i) begin
                    sel_d   = sel_i;
                    mode_d  = mode_i;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                got_d = got_n;
                if ((|got_q) && (cnt_q != CntMax)) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (done || expire) begin
                    timeout_d   = expire;
                    oup_data_d  = masked;
                    oup_mask_d  = got_n;
                    oup_valid_d = 1'b1;
                    state_d     = OUTPUT;
                end
            end
            OUTPUT: begin
                data_d = data_q;
                if (oup_ready_i) begin
                    got_d       = '0;
                    cnt_d       = '0;
                    timeout_d   = 1'b0;
                    oup_data_d  = '0;
                    oup_mask_d  = '0;
                    oup_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            mode_q      <= ALL;
            got_q       <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
            oup_data_q  <= '0;
            oup_mask_q  <= '0;
            oup_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            mode_q      <= mode_d;
            got_q       <= got_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
            oup_data_q  <= oup_data_d;
            oup_mask_q  <= oup_mask_d;
            oup_valid_q <= oup_valid_d;
            busy_q      <= busy_d;
        end
    end

endmodule
